fb_fill_writer: RTL and testbench

//  Avalon-MM write-side DMA for the SDRAM framebuffer: fills a run of 32-bit words with one

---
 rtl/fb_fill_pkg.sv | 24 ++
 rtl/fb_fill_regs.sv | 76 +++++++
 rtl/fb_fill_writer.sv | 125 ++++++++++++
 tb/tb_fb_fill_writer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fb_fill_pkg.sv
// Shared definitions for the framebuffer fill writer: register map, status bits, FSM states.
// The irq output is present only when FB_FILL_IRQ_EN is defined.
package fb_fill_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_DST    = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_COLOUR = 2'd3;

    localparam int CTRL_START   = 0;
    localparam int CTRL_ABORT   = 1;
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ABORTED = 2;

    localparam int ADDR_STEP_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/fb_fill_regs.sv
// Avalon slave register file: programmed fill parameters, sticky done/aborted status,
// and START/ABORT strobes already qualified against the busy state.
module fb_fill_regs
    import fb_fill_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int COUNT_W = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         address,
    input  logic               read_en,
    input  logic               write_en,
    input  logic [DATA_W-1:0]  write_data,
    output logic [DATA_W-1:0]  read_data,
    input  logic               busy,
    input  logic [COUNT_W-1:0] remaining,
    input  logic               set_done,
    input  logic               set_aborted,
    output logic               start,
    output logic               abort,
    output logic [31:0]        dst_addr,
    output logic [COUNT_W-1:0] count,
    output logic [DATA_W-1:0]  colour,
    output logic               done,
    output logic               aborted
);

    logic ctrl_wr, ctrl_rd;

    assign ctrl_wr = write_en && (address == REG_CTRL);
    assign ctrl_rd = read_en && (address == REG_CTRL);
    // A START while busy and an ABORT while idle are dropped here, so the FSM never sees them.
    assign start   = ctrl_wr && write_data[CTRL_START] && !busy;
    assign abort   = ctrl_wr && write_data[CTRL_ABORT] && busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dst_addr <= '0;
            count    <= '0;
            colour   <= '0;
            done     <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            if (write_en && !busy) begin
                case (address)
                    REG_DST:    dst_addr <= write_data[31:0];
                    REG_COUNT:  count    <= write_data[COUNT_W-1:0];
                    REG_COLOUR: colour   <= write_data;
                    default: ;
                endcase
            end
            if (set_done)                done <= 1'b1;
            else if (start || ctrl_rd)   done <= 1'b0;
            if (set_aborted)             aborted <= 1'b1;
            else if (start || ctrl_rd)   aborted <= 1'b0;
        end
    end

    always_comb begin
        read_data = '0;
        if (read_en) begin
            case (address)
                REG_CTRL: begin
                    read_data[STAT_BUSY]    = busy;
                    read_data[STAT_DONE]    = done;
                    read_data[STAT_ABORTED] = aborted;
                end
                REG_DST:    read_data = DATA_W'(dst_addr);
                REG_COUNT:  read_data = DATA_W'(busy ? remaining : count);
                default:    read_data = colour;
            endcase
        end
    end

endmodule

// File: rtl/fb_fill_writer.sv
// Framebuffer fill DMA: writes COUNT copies of COLOUR to SDRAM starting at DST_ADDR via an
// Avalon master. Define FB_FILL_IRQ_EN to add the irq output.
module fb_fill_writer
    import fb_fill_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int COUNT_W   = 24,
    parameter int ADDR_STEP = ADDR_STEP_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          slave_address,
    input  logic                slave_read_en,
    input  logic                slave_write_en,
    output logic [DATA_W-1:0]   slave_read_data,
    input  logic [DATA_W-1:0]   slave_write_data,
    output logic [31:0]         master_address,
    output logic                master_write,
    output logic [DATA_W-1:0]   master_write_data,
    output logic [DATA_W/8-1:0] master_byteenable,
    input  logic                master_wait_request
`ifdef FB_FILL_IRQ_EN
    ,output logic               irq
`endif
);

    state_t               state, state_nxt;
    logic [31:0]          addr_q;
    logic [COUNT_W-1:0]   rem_q;
    logic [DATA_W-1:0]    colour_q;
    logic                 busy, start, abort, load, accept;
    logic                 set_done, set_aborted, done, aborted;
    logic [31:0]          dst_addr;
    logic [COUNT_W-1:0]   count;
    logic [DATA_W-1:0]    colour;

    fb_fill_regs #(.DATA_W(DATA_W), .COUNT_W(COUNT_W)) u_regs (
        .clk         (clk),
        .reset       (reset),
        .address     (slave_address),
        .read_en     (slave_read_en),
        .write_en    (slave_write_en),
        .write_data  (slave_write_data),
        .read_data   (slave_read_data),
        .busy        (busy),
        .remaining   (rem_q),
        .set_done    (set_done),
        .set_aborted (set_aborted),
        .start       (start),
        .abort       (abort),
        .dst_addr    (dst_addr),
        .count       (count),
        .colour      (colour),
        .done        (done),
        .aborted     (aborted)
    );

    assign busy              = (state != ST_IDLE);
    assign load              = start && (count != '0);
    assign master_write      = busy;
    assign accept            = master_write && !master_wait_request;
    assign master_address    = addr_q;
    assign master_write_data = colour_q;
    assign master_byteenable = '1;

`ifdef FB_FILL_IRQ_EN
    assign irq = done | aborted;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        set_done    = 1'b0;
        set_aborted = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load)
                    state_nxt = ST_WRITE;
                else if (start)
                    set_done = 1'b1;
            end
            ST_WRITE: begin
                // An unaccepted request must stay on the bus, so an abort under stall drains first.
                if (abort) begin
                    if (master_wait_request) begin
                        state_nxt = ST_DRAIN;
                    end else begin
                        state_nxt   = ST_IDLE;
                        set_aborted = 1'b1;
                    end
                end else if (accept && rem_q == COUNT_W'(1)) begin
                    state_nxt = ST_IDLE;
                    set_done  = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (accept) begin
                    state_nxt   = ST_IDLE;
                    set_aborted = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q   <= '0;
            rem_q    <= '0;
            colour_q <= '0;
        end else if (load) begin
            addr_q   <= dst_addr;
            rem_q    <= count;
            colour_q <= colour;
        end else if (accept) begin
            addr_q <= addr_q + 32'(ADDR_STEP);
            rem_q  <= rem_q - COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fb_fill_writer.sv
// Directed bench for fb_fill_writer: expected master writes go to a scoreboard queue when a
// fill is started and are popped as the master bus accepts each word.
module tb_fb_fill_writer;

    logic        clk;
    logic        reset;
    logic [1:0]  slave_address;
    logic        slave_read_en;
    logic        slave_write_en;
    logic [31:0] slave_read_data;
    logic [31:0] slave_write_data;
    logic [31:0] master_address;
    logic        master_write;
    logic [31:0] master_write_data;
    logic [3:0]  master_byteenable;
    logic        master_wait_request;
`ifdef FB_FILL_IRQ_EN
    logic        irq;
`endif

    fb_fill_writer dut (
        .clk                 (clk),
        .reset               (reset),
        .slave_address       (slave_address),
        .slave_read_en       (slave_read_en),
        .slave_write_en      (slave_write_en),
        .slave_read_data     (slave_read_data),
        .slave_write_data    (slave_write_data),
        .master_address      (master_address),
        .master_write        (master_write),
        .master_write_data   (master_write_data),
        .master_byteenable   (master_byteenable),
        .master_wait_request (master_wait_request)
`ifdef FB_FILL_IRQ_EN
        ,.irq                (irq)
`endif
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  n_acc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scores any transfer accepted at the coming edge, then advances one clock.
    task automatic tick();
        wr_t w;
        if (master_write === 1'b1 && master_wait_request === 1'b0) begin
            n_acc++;
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL sb_underflow observed=%h expected=none", master_address);
            end
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                chk("wr_addr", master_address, w.addr);
                chk("wr_data", master_write_data, w.data);
                chk("wr_be", 32'(master_byteenable), 32'hF);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        slave_address    = a;
        slave_write_data = d;
        slave_write_en   = 1'b1;
        tick();
        slave_write_en   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        slave_address = a;
        slave_read_en = 1'b1;
        #1;
        chk(tag, slave_read_data, exp);
        tick();
        slave_read_en = 1'b0;
    endtask

    task automatic push_fill(input logic [31:0] base, input int n, input logic [31:0] col);
        for (int i = 0; i < n; i++) exp_q.push_back('{addr: base + 32'(4 * i), data: col});
    endtask

    int acc0;

    initial begin
        reset = 1'b0;
        slave_address = '0;
        slave_read_en = 1'b0;
        slave_write_en = 1'b0;
        slave_write_data = '0;
        master_wait_request = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_mwrite", 32'(master_write), 32'd0);
        chk("rst_maddr", master_address, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        rd_chk("rst_r0", 2'd0, 32'h0);
        rd_chk("rst_r2", 2'd2, 32'h0);

        // 1: three-word fill, no stalls
        wr(2'd1, 32'h100);
        wr(2'd2, 32'd3);
        wr(2'd3, 32'hFF00FF00);
        push_fill(32'h100, 3, 32'hFF00FF00);
        acc0 = n_acc;
        wr(2'd0, 32'h1);
        chk("t1_write_after_start", 32'(master_write), 32'd1);
        repeat (3) tick();
        chk("t1_accepts", 32'(n_acc - acc0), 32'd3);
        chk("t1_write_low", 32'(master_write), 32'd0);
        rd_chk("t1_status", 2'd0, 32'h2);

        // 2: stall on the second word
        push_fill(32'h100, 3, 32'hFF00FF00);
        acc0 = n_acc;
        wr(2'd0, 32'h1);
        rd_chk("t2_r2_3", 2'd2, 32'd3);
        master_wait_request = 1'b1;
        rd_chk("t2_r2_2a", 2'd2, 32'd2);
        for (int i = 0; i < 4; i++) begin
            chk("t2_hold_addr", master_address, 32'h104);
            chk("t2_hold_data", master_write_data, 32'hFF00FF00);
            tick();
        end
        master_wait_request = 1'b0;
        rd_chk("t2_r2_2b", 2'd2, 32'd2);
        rd_chk("t2_r2_1", 2'd2, 32'd1);
        chk("t2_accepts", 32'(n_acc - acc0), 32'd3);
        rd_chk("t2_r2_idle", 2'd2, 32'd3);
        rd_chk("t2_status", 2'd0, 32'h2);

        // 3: zero-length fill
        acc0 = n_acc;
        wr(2'd2, 32'd0);
        wr(2'd0, 32'h1);
        chk("t3_no_write", 32'(master_write), 32'd0);
`ifdef FB_FILL_IRQ_EN
        chk("t3_irq", 32'(irq), 32'd1);
`endif
        rd_chk("t3_status1", 2'd0, 32'h2);
        rd_chk("t3_status2", 2'd0, 32'h0);
        chk("t3_accepts", 32'(n_acc - acc0), 32'd0);

        // 4: abort under stall after four accepts
        wr(2'd2, 32'd10);
        push_fill(32'h100, 5, 32'hFF00FF00);
        acc0 = n_acc;
        wr(2'd0, 32'h1);
        repeat (4) tick();
        master_wait_request = 1'b1;
        wr(2'd0, 32'h2);
        for (int i = 0; i < 3; i++) begin
            chk("t4_drain_write", 32'(master_write), 32'd1);
            chk("t4_drain_addr", master_address, 32'h110);
            tick();
        end
        master_wait_request = 1'b0;
        tick();
        chk("t4_write_low", 32'(master_write), 32'd0);
        chk("t4_accepts", 32'(n_acc - acc0), 32'd5);
        rd_chk("t4_status", 2'd0, 32'h4);

        // 5: address wrap, register write while busy
        wr(2'd1, 32'hFFFFFFFC);
        wr(2'd2, 32'd2);
        exp_q.push_back('{addr: 32'hFFFFFFFC, data: 32'hFF00FF00});
        exp_q.push_back('{addr: 32'h00000000, data: 32'hFF00FF00});
        wr(2'd0, 32'h1);
        wr(2'd1, 32'h1234);
        tick();
        rd_chk("t5_r1", 2'd1, 32'hFFFFFFFC);
        rd_chk("t5_status", 2'd0, 32'h2);

        // 6: reset in the middle of a stalled fill
        wr(2'd1, 32'h200);
        wr(2'd2, 32'd5);
        master_wait_request = 1'b1;
        wr(2'd0, 32'h1);
        chk("t6_busy", 32'(master_write), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_drop", 32'(master_write), 32'd0);
        tick();
        reset = 1'b0;
        master_wait_request = 1'b0;
        rd_chk("t6_r0", 2'd0, 32'h0);
        rd_chk("t6_r1", 2'd1, 32'h0);
        rd_chk("t6_r2", 2'd2, 32'h0);
        rd_chk("t6_r3", 2'd3, 32'h0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
